sha256_target_checker: RTL

//   Consumer end of the sha256 core: accepts each finished digest and its nonce over a valid/ready handshake.

---
 rtl/sha256_miner_pkg.sv | 34 +++
 rtl/sha256_target_checker.sv | 130 +++++++++++++
 2 files changed

// File: rtl/sha256_miner_pkg.sv
// ============================================================================
// Module : sha256_miner_pkg
// Brief  : Shared types, word-select constants and helpers for the sha256 miner.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sha256_miner_pkg;

  localparam int DIGEST_WORDS = 8;
  localparam int WORD_IDX_W   = 3;

  // H0 occupies the most significant word of a digest, H7 the least.
  localparam logic [WORD_IDX_W-1:0] WORD_H0 = 3'd7;
  localparam logic [WORD_IDX_W-1:0] WORD_H7 = 3'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMP    = 2'd1,
    REPORT = 2'd2
  } state_e;

  function automatic logic [255:0] byte_reverse256(input logic [255:0] d);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[8*i +: 8] = d[255-8*i -: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_target_checker.sv
// ============================================================================
// Module : sha256_target_checker
// Brief  : Checks finished digests (Bitcoin byte order) against a difficulty
//          target one 32-bit word per cycle and reports hits with their nonce.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sha256_target_checker
  import sha256_miner_pkg::*;
#(
  parameter int DIGEST_W = 256,
  parameter int WORD_W   = 32,
  parameter int NONCE_W  = 32,
  parameter int CNT_W    = 48
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                digest_valid,
  output logic                digest_ready,
  input  logic [DIGEST_W-1:0] digest,
  input  logic [NONCE_W-1:0]  digest_nonce,
  input  logic [DIGEST_W-1:0] target,
  input  logic                clear,
  output logic                found_valid,
  input  logic                found_ready,
  output logic [NONCE_W-1:0]  found_nonce,
  output logic [DIGEST_W-1:0] found_value,
  output logic [CNT_W-1:0]    hash_count,
  output logic                busy
);

  state_e                  state_q, state_d;
  logic [DIGEST_W-1:0]     val_q, val_d;
  logic [DIGEST_W-1:0]     tgt_q, tgt_d;
  logic [NONCE_W-1:0]      nonce_q, nonce_d;
  logic [WORD_IDX_W-1:0]   k_q, k_d;
  logic [NONCE_W-1:0]      found_nonce_q, found_nonce_d;
  logic [DIGEST_W-1:0]     found_value_q, found_value_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [WORD_W-1:0]       val_word;
  logic [WORD_W-1:0]       tgt_word;
  logic                    word_lt;
  logic                    word_gt;

  // One shared comparator walks from the most significant word downward.
  assign val_word = val_q[int'(k_q)*WORD_W +: WORD_W];
  assign tgt_word = tgt_q[int'(k_q)*WORD_W +: WORD_W];
  assign word_lt  = (val_word < tgt_word);
  assign word_gt  = (val_word > tgt_word);

  always_comb begin
    state_d       = state_q;
    val_d         = val_q;
    tgt_d         = tgt_q;
    nonce_d       = nonce_q;
    k_d           = k_q;
    found_nonce_d = found_nonce_q;
    found_value_d = found_value_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        if (digest_valid) begin
          val_d   = byte_reverse256(digest);
          tgt_d   = target;
          nonce_d = digest_nonce;
          k_d     = WORD_H0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = CMP;
        end
      end
      CMP: begin
        // Equality on the last word still counts as a hit (value == target).
        if (word_lt || (!word_gt && (k_q == WORD_H7))) begin
          found_nonce_d = nonce_q;
          found_value_d = val_q;
          state_d       = REPORT;
        end else if (word_gt) begin
          state_d = IDLE;
        end else begin
          k_d = k_q - WORD_IDX_W'(1);
        end
      end
      REPORT: begin
        if (found_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      val_q         <= '0;
      tgt_q         <= '0;
      nonce_q       <= '0;
      k_q           <= '0;
      found_nonce_q <= '0;
      found_value_q <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      val_q         <= val_d;
      tgt_q         <= tgt_d;
      nonce_q       <= nonce_d;
      k_q           <= k_d;
      found_nonce_q <= found_nonce_d;
      found_value_q <= found_value_d;
      cnt_q         <= cnt_d;
    end
  end

  assign digest_ready = (state_q == IDLE);
  assign found_valid  = (state_q == REPORT);
  assign busy         = (state_q != IDLE);
  assign found_nonce  = found_nonce_q;
  assign found_value  = found_value_q;
  assign hash_count   = cnt_q;

endmodule

`default_nettype wire
